// File: rtl/branch_predict_ctrl_pkg.sv
// Shared encodings for the branch predictor: counter states, reset value,
// controller FSM states and the B-type funct3 codes.
package branch_predict_ctrl_pkg;

    // 2-bit saturating counter encodings
    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } ctr_e;

    // Every table entry starts weakly not-taken
    localparam logic [1:0] CTR_RESET = CtrWnt;

    // Resolution sequencer states
    typedef enum logic {
        StRun      = 1'b0,
        StRedirect = 1'b1
    } state_e;

    // RV32I branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// 2-bit saturating up/down counter, one per branch history table entry.
module sat_counter2
    import branch_predict_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] value
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next count: step toward taken/not-taken, holding at either end
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != CtrSt)) begin
            cnt_d = cnt_q + 2'd1;
        end else if (dec && (cnt_q != CtrSnt)) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Counter state, weakly not-taken out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= CTR_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch direction predictor (table of 2-bit counters) plus the EX-stage
// resolution sequencer that trains the table and issues redirect/flush.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_taken,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    state_e          state_q;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic            res;
    logic            mis;
    logic [1:0]      bht [BHT_ENTRIES];

    // Word-aligned PCs: byte offset and bits above the index don't select an entry
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Wrong-path EX contents during the redirect cycle are never resolved
    assign res = ex_valid & ex_branch & ~stall & (state_q == StRun);
    assign mis = res & (ex_taken != ex_pred_taken);

    // No bypass: a same-cycle update shows up on the next cycle
    assign if_pred_taken = bht[if_idx][1];

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        logic hit;
        assign hit = res & (ex_idx == IDX_W'(i));
        sat_counter2 u_ctr (
            .clk   (clk),
            .rst   (rst),
            .inc   (hit & ex_taken),
            .dec   (hit & ~ex_taken),
            .value (bht[i])
        );
    end

    // Resolution FSM with registered redirect/flush and event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StRun;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (mis) begin
                        state_q        <= StRedirect;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        redirect_pc    <= ex_taken ? ex_target : ex_pc + XLEN'(4);
                    end else begin
                        redirect_valid <= 1'b0;
                        flush          <= 1'b0;
                    end
                end
                StRedirect: begin
                    // One-cycle pulse, leaves even under stall
                    state_q        <= StRun;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                end
                default: begin
                    state_q        <= StRun;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                end
            endcase
            if (res) branch_cnt  <= branch_cnt + 32'd1;
            if (mis) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with hand-computed expectations.
module tb_branch_predict_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks   = 0;
    int failures = 0;

    branch_predict_ctrl #(
        .BHT_ENTRIES (16),
        .IDX_W       (4),
        .XLEN        (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_taken       (ex_taken),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic taken, input logic pred, input logic [31:0] pc,
                           input logic [31:0] tgt);
        ex_valid      = 1'b1;
        ex_branch     = 1'b1;
        ex_taken      = taken;
        ex_pred_taken = pred;
        ex_pc         = pc;
        ex_target     = tgt;
    endtask

    task automatic idle_ex();
        ex_valid  = 1'b0;
        ex_branch = 1'b0;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check_eq(tag, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    task automatic check_state(input string tag, input logic rv, input logic [31:0] bc,
                               input logic [31:0] mc);
        check_eq({tag, "_rv"}, {31'd0, redirect_valid}, {31'd0, rv});
        check_eq({tag, "_fl"}, {31'd0, flush}, {31'd0, rv});
        check_eq({tag, "_bc"}, branch_cnt, bc);
        check_eq({tag, "_mc"}, mispred_cnt, mc);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; if_pc = '0;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
        ex_pc = '0; ex_target = '0;
        #23 rst = 1'b1;
        step();

        // Reset/idle
        for (int i = 0; i < 16; i++) pred_at("rst_pred", 32'(i * 4), 1'b0);
        check_state("rst", 1'b0, 32'd0, 32'd0);
        check_eq("rst_rpc", redirect_pc, 32'h0);

        // Taken mispredict at 0x40 -> redirect to 0x80, bht[0] 01->10
        present(1'b1, 1'b0, 32'h40, 32'h80);
        step(); idle_ex();
        check_state("mis1", 1'b1, 32'd1, 32'd1);
        check_eq("mis1_rpc", redirect_pc, 32'h80);
        pred_at("mis1_pred", 32'h40, 1'b1);
        step();
        check_state("mis1_end", 1'b0, 32'd1, 32'd1);

        // Four correct taken outcomes: bht[0] saturates at 11
        for (int i = 0; i < 4; i++) begin
            present(1'b1, 1'b1, 32'h40, 32'h80);
            step();
            check_eq("corr_rv", {31'd0, redirect_valid}, 32'd0);
        end
        idle_ex();
        check_state("corr", 1'b0, 32'd5, 32'd1);
        pred_at("corr_pred", 32'h40, 1'b1);

        // Two not-taken: 11->10 (still taken), 10->01 (not taken)
        present(1'b0, 1'b1, 32'h40, 32'h80);
        step(); idle_ex();
        check_state("nt1", 1'b1, 32'd6, 32'd2);
        check_eq("nt1_rpc", redirect_pc, 32'h44);
        pred_at("nt1_pred", 32'h40, 1'b1);
        step();
        present(1'b0, 1'b1, 32'h40, 32'h80);
        step(); idle_ex();
        check_state("nt2", 1'b1, 32'd7, 32'd3);
        pred_at("nt2_pred", 32'h40, 1'b0);
        step();

        // Predicted-taken at 0x44 resolves not-taken; branch in EX during redirect ignored
        present(1'b0, 1'b1, 32'h44, 32'h10);
        step();
        present(1'b1, 1'b0, 32'h48, 32'h90);
        check_state("nt44", 1'b1, 32'd8, 32'd4);
        check_eq("nt44_rpc", redirect_pc, 32'h48);
        step(); idle_ex();
        check_state("ign", 1'b0, 32'd8, 32'd4);
        check_eq("ign_rpc", redirect_pc, 32'h48);
        pred_at("ign_pred", 32'h48, 1'b0);
        step();
        check_eq("ign_rv2", {31'd0, redirect_valid}, 32'd0);

        // Stalled mispredict: nothing until release, then redirect one edge later
        stall = 1'b1;
        present(1'b1, 1'b0, 32'h10C, 32'h200);
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("stall", 1'b0, 32'd8, 32'd4);
        end
        pred_at("stall_pred", 32'h10C, 1'b0);
        stall = 1'b0;
        step(); idle_ex();
        stall = 1'b1;
        check_state("rel", 1'b1, 32'd9, 32'd5);
        check_eq("rel_rpc", redirect_pc, 32'h200);
        pred_at("rel_pred", 32'h10C, 1'b1);
        step();
        check_state("rel_end", 1'b0, 32'd9, 32'd5);
        stall = 1'b0;

        // PC+4 wraps at the top of the address space
        present(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        step(); idle_ex();
        check_state("wrap", 1'b1, 32'd10, 32'd6);
        check_eq("wrap_rpc", redirect_pc, 32'h0);
        step();

        // Async reset mid-redirect
        present(1'b1, 1'b0, 32'h20, 32'h300);
        step(); idle_ex();
        check_state("pre_rst", 1'b1, 32'd11, 32'd7);
        check_eq("pre_rst_rpc", redirect_pc, 32'h300);
        #2 rst = 1'b0;
        #1;
        check_state("arst", 1'b0, 32'd0, 32'd0);
        check_eq("arst_rpc", redirect_pc, 32'h0);
        for (int i = 0; i < 16; i++) pred_at("arst_pred", 32'(i * 4), 1'b0);
        rst = 1'b1;
        step();
        check_state("post_rst", 1'b0, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
